// File: rtl/nic_mac_reset_sequencer.sv
// nic_mac_reset_sequencer: sequences the Ethernet MAC active-low reset for the NIC core.
// Commands (NOP/PULSE/HOLD/RELEASE) arrive on a req/ack pipe. The MAC reset is held,
// pulsed for ASSERT_CYCLES, or released through a SETTLE_CYCLES interval before
// mac_ready. Every state change is reported as a byte on the status pipe.
// Optional feature macro: MAC_LINK_WATCHDOG_EN adds a link-loss watchdog that
// re-pulses the MAC after LINK_DOWN_CYCLES consecutive link-down cycles in RUN.
module nic_mac_reset_sequencer #(
    parameter int unsigned ASSERT_CYCLES    = 64,
    parameter int unsigned SETTLE_CYCLES    = 256,
    parameter int unsigned LINK_DOWN_CYCLES = 1024,
    parameter int unsigned CNT_W            = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] MAC_CTRL_pipe_data,
    input  logic       MAC_CTRL_pipe_req,
    output logic       MAC_CTRL_pipe_ack,
    output logic [7:0] MAC_STATUS_pipe_data,
    output logic       MAC_STATUS_pipe_req,
    input  logic       MAC_STATUS_pipe_ack,
    input  logic       mac_link_up,
    output logic       NIC_TO_MAC_RESET_N,
    output logic       mac_ready
);

    localparam int unsigned RC_W = 3;

    localparam logic [CNT_W-1:0] ASSERT_LOAD = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] CMD_NOP     = 2'b00;
    localparam logic [1:0] CMD_PULSE   = 2'b01;
    localparam logic [1:0] CMD_HOLD    = 2'b10;
    localparam logic [1:0] CMD_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        ST_HELD   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic              rst_n_q;
    logic              ready_q;
    logic              ack_q;
    logic [7:0]        st_data_q, st_data_d;
    logic              st_req_q, st_req_d;

    logic [1:0]        cmd;
    logic              cmd_accept;
    logic              settle_done;
    logic              wd_trig;
    logic              push;
    logic              st_take;

    assign cmd        = MAC_CTRL_pipe_data[1:0];
    assign cmd_accept = MAC_CTRL_pipe_req & ack_q;
    assign st_take    = st_req_q & MAC_STATUS_pipe_ack;

`ifdef MAC_LINK_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(LINK_DOWN_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             unused_cfg;

    assign unused_cfg = ^MAC_CTRL_pipe_data[7:2];

    // Watchdog: count consecutive link-down cycles in RUN; a command in the trigger cycle wins
    always_comb begin
        wd_trig  = 1'b0;
        wd_cnt_d = '0;
        if (state_q == ST_RUN && !mac_link_up) begin
            if (wd_cnt_q == WD_LAST) begin
                wd_trig = !cmd_accept;
            end else begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
        end
    end

    // Watchdog counter register; cleared whenever the FSM is not staying in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else if (state_d == ST_RUN) begin
            wd_cnt_q <= wd_cnt_d;
        end else begin
            wd_cnt_q <= '0;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{MAC_CTRL_pipe_data[7:2], 32'(LINK_DOWN_CYCLES)};
    assign wd_trig    = 1'b0;
`endif

    // Next-state, shared down-counter and reset_count
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        settle_done = 1'b0;
        case (state_q)
            ST_HELD: begin
                if (cmd_accept) begin
                    case (cmd)
                        CMD_PULSE: begin
                            state_d = ST_ASSERT;
                            cnt_d   = ASSERT_LOAD;
                        end
                        CMD_RELEASE: begin
                            state_d = ST_SETTLE;
                            cnt_d   = SETTLE_LOAD;
                        end
                        default: begin
                            state_d = ST_HELD;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (cmd_accept) begin
                    case (cmd)
                        CMD_PULSE: begin
                            state_d = ST_ASSERT;
                            cnt_d   = ASSERT_LOAD;
                        end
                        CMD_HOLD: begin
                            state_d = ST_HELD;
                        end
                        default: begin
                            state_d = ST_RUN;
                        end
                    endcase
                end else if (wd_trig) begin
                    state_d = ST_ASSERT;
                    cnt_d   = ASSERT_LOAD;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    rcnt_d  = rcnt_q + RC_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RUN;
                    settle_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_HELD;
                cnt_d   = '0;
            end
        endcase
    end

    assign push = cmd_accept | wd_trig | settle_done;

    // Single-entry status register; overwriting an untaken byte marks overflow
    always_comb begin
        st_req_d  = st_req_q;
        st_data_d = st_data_q;
        if (push) begin
            st_req_d  = 1'b1;
            st_data_d = {st_req_q & ~st_take, mac_link_up, 2'(state_d), 1'b0, rcnt_d};
        end else if (st_take) begin
            st_req_d = 1'b0;
        end
    end

    // State, counters, status and registered outputs derived from next-state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HELD;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            rst_n_q   <= 1'b0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b1;
            st_req_q  <= 1'b0;
            st_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            rst_n_q   <= (state_d == ST_SETTLE) || (state_d == ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            ack_q     <= (state_d == ST_HELD) || (state_d == ST_RUN);
            st_req_q  <= st_req_d;
            st_data_q <= st_data_d;
        end
    end

    assign MAC_CTRL_pipe_ack    = ack_q;
    assign MAC_STATUS_pipe_data = st_data_q;
    assign MAC_STATUS_pipe_req  = st_req_q;
    assign NIC_TO_MAC_RESET_N   = rst_n_q;
    assign mac_ready            = ready_q;

endmodule

// File: tb/tb_nic_mac_reset_sequencer.sv
// tb_nic_mac_reset_sequencer: command table plus hand sequences for pulse width,
// status overflow, watchdog (when MAC_LINK_WATCHDOG_EN is defined) and mid-sequence reset.
module tb_nic_mac_reset_sequencer;

    localparam int unsigned A  = 3;
    localparam int unsigned S  = 4;
    localparam int unsigned L  = 5;
    localparam int unsigned NV = 10;

    localparam logic [1:0] HELD   = 2'd0;
    localparam logic [1:0] ASSERT = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] RUN    = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ctrl_data;
    logic       ctrl_req;
    logic       ctrl_ack;
    logic [7:0] st_data;
    logic       st_req;
    logic       st_ack;
    logic       link;
    logic       rst_n;
    logic       ready;

    always #5 clk = ~clk;

    nic_mac_reset_sequencer #(
        .ASSERT_CYCLES   (A),
        .SETTLE_CYCLES   (S),
        .LINK_DOWN_CYCLES(L),
        .CNT_W           (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .MAC_CTRL_pipe_data  (ctrl_data),
        .MAC_CTRL_pipe_req   (ctrl_req),
        .MAC_CTRL_pipe_ack   (ctrl_ack),
        .MAC_STATUS_pipe_data(st_data),
        .MAC_STATUS_pipe_req (st_req),
        .MAC_STATUS_pipe_ack (st_ack),
        .mac_link_up         (link),
        .NIC_TO_MAC_RESET_N  (rst_n),
        .mac_ready           (ready)
    );

    typedef struct {
        logic [7:0] cmd;
        logic [1:0] st1;
        logic [1:0] st_fin;
        logic [2:0] rc_fin;
    } vec_t;

    vec_t       vecs[NV];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic       exp_pend = 1'b0;
    logic [2:0] exp_rc   = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sbyte(input logic ovf, input logic lk,
                                         input logic [1:0] st, input logic [2:0] rc);
        return {ovf, lk, st, 1'b0, rc};
    endfunction

    // Expected byte for a push at the edge just taken; an untaken pending byte is replaced
    task automatic expect_push(input logic [1:0] st, input logic [2:0] rc, input logic lk);
        logic ovf;
        ovf = exp_pend;
        if (exp_pend && exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(sbyte(ovf, lk, st, rc));
        exp_pend = 1'b1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        int n;
        n = 0;
        while (!ctrl_ack && n < 100) begin
            step();
            n++;
        end
        if (!ctrl_ack) begin
            total++;
            bad++;
            $display("FAIL ctrl_ack_timeout: got %0h want 1", ctrl_ack);
        end
        ctrl_data = c;
        ctrl_req  = 1'b1;
        step();
        ctrl_req  = 1'b0;
    endtask

    // Scoreboard: compare each status byte the consumer takes on the coming edge
    always @(negedge clk) begin
        if (!reset && st_req && st_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL status_unexpected: got %0h want none", st_data);
            end else begin
                check("status_byte", 32'(st_data), 32'(exp_q.pop_front()));
            end
            exp_pend = 1'b0;
        end
    end

    initial begin
        int low;
        int settle;
        int ack_err;
        int n;
        int viol;

        vecs[0] = '{8'h02, HELD,   HELD, 3'd0};
        vecs[1] = '{8'h00, HELD,   HELD, 3'd0};
        vecs[2] = '{8'hFC, HELD,   HELD, 3'd0};
        vecs[3] = '{8'h03, SETTLE, RUN,  3'd0};
        vecs[4] = '{8'h03, RUN,    RUN,  3'd0};
        vecs[5] = '{8'hA4, RUN,    RUN,  3'd0};
        vecs[6] = '{8'h02, HELD,   HELD, 3'd0};
        vecs[7] = '{8'h05, ASSERT, RUN,  3'd1};
        vecs[8] = '{8'hFE, HELD,   HELD, 3'd1};
        vecs[9] = '{8'h07, SETTLE, RUN,  3'd1};

        reset     = 1'b1;
        ctrl_data = 8'h00;
        ctrl_req  = 1'b0;
        st_ack    = 1'b1;
        link      = 1'b1;
        repeat (3) step();
        check("rst_during_reset", 32'(rst_n), 0);
        check("ack_during_reset", 32'(ctrl_ack), 1);
        reset = 1'b0;
        repeat (10) step();
        check("idle_rst_n", 32'(rst_n), 0);
        check("idle_ready", 32'(ready), 0);
        check("idle_ack", 32'(ctrl_ack), 1);
        check("idle_st_req", 32'(st_req), 0);

        // Command table
        for (int i = 0; i < NV; i++) begin
            send_cmd(vecs[i].cmd);
            expect_push(vecs[i].st1, exp_rc, 1'b1);
            check($sformatf("v%0d_rst_n", i), 32'(rst_n),
                  32'(vecs[i].st1 == SETTLE || vecs[i].st1 == RUN));
            check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].st1 == RUN));
            check($sformatf("v%0d_ack", i), 32'(ctrl_ack),
                  32'(vecs[i].st1 == HELD || vecs[i].st1 == RUN));
            if (vecs[i].st_fin == RUN && vecs[i].st1 != RUN)
                exp_q.push_back(sbyte(1'b0, 1'b1, RUN, vecs[i].rc_fin));
            exp_rc = vecs[i].rc_fin;
            repeat (A + S + 4) step();
            check($sformatf("v%0d_fin_rst_n", i), 32'(rst_n),
                  32'(vecs[i].st_fin == SETTLE || vecs[i].st_fin == RUN));
            check($sformatf("v%0d_fin_ready", i), 32'(ready), 32'(vecs[i].st_fin == RUN));
            check($sformatf("v%0d_fin_ack", i), 32'(ctrl_ack),
                  32'(vecs[i].st_fin == HELD || vecs[i].st_fin == RUN));
            check($sformatf("v%0d_fin_st_req", i), 32'(st_req), 0);
        end

        // PULSE from RUN: exact low width, settle length, back-pressure
        send_cmd(8'h01);
        expect_push(ASSERT, exp_rc, 1'b1);
        exp_q.push_back(sbyte(1'b0, 1'b1, RUN, exp_rc + 3'd1));
        exp_rc  = exp_rc + 3'd1;
        low     = 0;
        settle  = 0;
        ack_err = 0;
        n       = 0;
        while (!rst_n && n < 40) begin
            if (ctrl_ack) ack_err++;
            low++;
            n++;
            step();
        end
        while (!ready && n < 40) begin
            if (ctrl_ack || !rst_n) ack_err++;
            settle++;
            n++;
            step();
        end
        check("pulse_low_cycles", 32'(low), A);
        check("pulse_settle_cycles", 32'(settle), S);
        check("pulse_ack_low", 32'(ack_err), 0);
        check("pulse_ack_back", 32'(ctrl_ack), 1);
        repeat (3) step();

        // Status stall across pushes: overflow set and sticky, cleared after consume
        st_ack = 1'b0;
        send_cmd(8'h00);
        expect_push(RUN, exp_rc, 1'b1);
        check("stall1_bit7", 32'(st_data[7]), 0);
        send_cmd(8'h00);
        expect_push(RUN, exp_rc, 1'b1);
        check("ovf_set_bit7", 32'(st_data[7]), 1);
        send_cmd(8'h00);
        expect_push(RUN, exp_rc, 1'b1);
        check("ovf_sticky_bit7", 32'(st_data[7]), 1);
        st_ack = 1'b1;
        step();
        check("ovf_consumed_req", 32'(st_req), 0);
        send_cmd(8'h00);
        expect_push(RUN, exp_rc, 1'b1);
        check("ovf_cleared_bit7", 32'(st_data[7]), 0);
        repeat (3) step();

        // Push in the same cycle as a consume
        st_ack = 1'b0;
        send_cmd(8'h00);
        expect_push(RUN, exp_rc, 1'b1);
        st_ack    = 1'b1;
        ctrl_data = 8'h00;
        ctrl_req  = 1'b1;
        step();
        ctrl_req = 1'b0;
        expect_push(RUN, exp_rc, 1'b1);
        check("push_consume_req", 32'(st_req), 1);
        check("push_consume_bit7", 32'(st_data[7]), 0);
        repeat (3) step();

`ifdef MAC_LINK_WATCHDOG_EN
        // Watchdog: 4 link-down cycles tolerated, 5 trigger a pulse
        viol = 0;
        link = 1'b0;
        repeat (4) step();
        link = 1'b1;
        repeat (8) begin
            step();
            if (!rst_n || !ready) viol++;
        end
        check("wd_short_no_reset", 32'(viol), 0);
        link = 1'b0;
        repeat (4) step();
        check("wd_before_trig_rst_n", 32'(rst_n), 1);
        step();
        check("wd_trig_rst_n", 32'(rst_n), 0);
        check("wd_trig_ready", 32'(ready), 0);
        expect_push(ASSERT, exp_rc, 1'b0);
        exp_q.push_back(sbyte(1'b0, 1'b1, RUN, exp_rc + 3'd1));
        exp_rc = exp_rc + 3'd1;
        link   = 1'b1;
        repeat (A + S + 4) step();
        check("wd_recover_ready", 32'(ready), 1);
`else
        // Without the watchdog a long link loss leaves the MAC running
        viol = 0;
        link = 1'b0;
        repeat (L + 10) begin
            step();
            if (!rst_n || !ready) viol++;
        end
        check("nowd_link_down_run", 32'(viol), 0);
        link = 1'b1;
        step();
`endif

        // Link bit in the status byte
        link = 1'b0;
        send_cmd(8'h00);
        expect_push(RUN, exp_rc, 1'b0);
        link = 1'b1;
        check("link_bit6", 32'(st_data[6]), 0);
        repeat (3) step();

        // HOLD from RUN, then reset during SETTLE
        send_cmd(8'h02);
        expect_push(HELD, exp_rc, 1'b1);
        check("hold_rst_n", 32'(rst_n), 0);
        check("hold_ready", 32'(ready), 0);
        repeat (3) step();
        st_ack = 1'b0;
        send_cmd(8'h03);
        expect_push(SETTLE, exp_rc, 1'b1);
        step();
        check("settle_rst_n", 32'(rst_n), 1);
        reset = 1'b1;
        void'(exp_q.pop_back());
        exp_pend = 1'b0;
        step();
        check("midrst_rst_n", 32'(rst_n), 0);
        check("midrst_ready", 32'(ready), 0);
        check("midrst_st_req", 32'(st_req), 0);
        check("midrst_ack", 32'(ctrl_ack), 1);
        reset  = 1'b0;
        st_ack = 1'b1;
        exp_rc = 3'd0;
        repeat (2) step();
        check("midrst_idle_st_req", 32'(st_req), 0);
        send_cmd(8'h03);
        expect_push(SETTLE, 3'd0, 1'b1);
        exp_q.push_back(sbyte(1'b0, 1'b1, RUN, 3'd0));
        repeat (S + 4) step();
        check("post_rst_ready", 32'(ready), 1);

        repeat (4) step();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nic_mac_reset_sequencer.md
# nic_mac_reset_sequencer

Sequences the active-low reset of the Ethernet MAC on behalf of the NIC core. Commands arrive over a req/ack pipe; the MAC reset is held, pulsed with a guaranteed minimum width, or released through a settle interval before the MAC is declared ready. A status pipe reports every state change back to the NIC core. An optional link watchdog re-pulses the MAC after a sustained link loss.

## Interface

Parameters:
- ASSERT_CYCLES, 64: cycles NIC_TO_MAC_RESET_N is held low per pulse; must be ≥1.
- SETTLE_CYCLES, 256: cycles after reset release before mac_ready asserts; must be ≥1.
- LINK_DOWN_CYCLES, 1024: consecutive link-down cycles in RUN that trigger an automatic pulse (watchdog only); must be ≥1.
- CNT_W, 16: width of the shared down-counter and the watchdog counter; must hold the largest parameter minus 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- MAC_CTRL_pipe_data  in  8  command; [1:0] = 00 NOP, 01 PULSE, 10 HOLD, 11 RELEASE; [7:2] ignored.
- MAC_CTRL_pipe_req  in  1  command valid.
- MAC_CTRL_pipe_ack  out  1  command accepted when req&ack.
- MAC_STATUS_pipe_data  out  8  status byte.
- MAC_STATUS_pipe_req  out  1  status byte pending.
- MAC_STATUS_pipe_ack  in  1  consumer takes byte when req&ack.
- mac_link_up  in  1  MAC link indication, already in the clk domain.
- NIC_TO_MAC_RESET_N  out  1  MAC reset, active low, registered.
- mac_ready  out  1  high only in RUN, registered.

## Operation

- States: HELD, ASSERT, SETTLE, RUN. Codes: HELD=0, ASSERT=1, SETTLE=2, RUN=3.
- Outputs per state: HELD/ASSERT → NIC_TO_MAC_RESET_N=0; SETTLE/RUN → 1. mac_ready=1 only in RUN. Both outputs are registered from next-state, so they change on the same edge as the state.
- MAC_CTRL_pipe_ack=1 only in HELD and RUN; it is 0 in ASSERT and SETTLE, which back-pressures the command pipe.
- HELD: RELEASE → SETTLE; PULSE → ASSERT; HOLD/NOP → stay.
- RUN: PULSE → ASSERT; HOLD → HELD; RELEASE/NOP → stay.
- ASSERT: on entry, counter loads ASSERT_CYCLES-1 and decrements each cycle. When it reaches 0: go to SETTLE and increment reset_count, a 3-bit counter that wraps mod 8.
- SETTLE: on entry, counter loads SETTLE_CYCLES-1. When it reaches 0: go to RUN.
- Status byte: [7]=overflow, [6]=mac_link_up, [5:4]=state code after the event, [3]=0, [2:0]=reset_count.
- Status push events:
  - every accepted command, including NOP;
  - SETTLE→RUN;
  - watchdog trigger.
- Status register holds one entry. Writing while a byte is pending and not being taken in the same cycle overwrites it and sets overflow. Overflow is sticky until a byte carrying it is consumed.
- Push in the same cycle as a consume: the new byte becomes pending, MAC_STATUS_pipe_req stays 1, and overflow is not set.
- Simultaneous accepted command and watchdog trigger in RUN: the command wins and the watchdog counter clears.

## Timing

- Reset values: state=HELD, NIC_TO_MAC_RESET_N=0, mac_ready=0, MAC_CTRL_pipe_ack=1, MAC_STATUS_pipe_req=0, MAC_STATUS_pipe_data=0, reset_count=0, counters=0, overflow=0.
- Reset asserted mid-sequence returns to HELD on the next edge. NIC_TO_MAC_RESET_N drops low on that edge and any pending status byte is discarded.
- PULSE accepted at edge N in RUN: NIC_TO_MAC_RESET_N is low from edge N+1 for exactly ASSERT_CYCLES cycles, then high. mac_ready returns after SETTLE_CYCLES further cycles.
- RELEASE accepted at edge N in HELD: NIC_TO_MAC_RESET_N high from edge N+1; mac_ready high from edge N+1+SETTLE_CYCLES.
- Status byte appears (req=1) on the edge after its triggering event.

## Configuration

- MAC_LINK_WATCHDOG_EN defined: in RUN, a counter counts consecutive cycles with mac_link_up=0 and clears on mac_link_up=1 or on leaving RUN.
  - When the count reaches LINK_DOWN_CYCLES, the FSM goes to ASSERT and pushes a status byte.
- Not defined: no watchdog logic; mac_link_up is only reported in status bit [6]; LINK_DOWN_CYCLES is unused.

## Test plan

- Reset, then idle 10 cycles → NIC_TO_MAC_RESET_N=0, mac_ready=0, ack=1, status req=0.
- RELEASE (0x03) with SETTLE_CYCLES=4 → RESET_N=1 next edge; mac_ready=1 four cycles later; status bytes: state=SETTLE, then state=RUN.
- From RUN, PULSE (0x01) with ASSERT_CYCLES=3 → RESET_N low exactly 3 cycles; ack=0 throughout ASSERT/SETTLE; reset_count=1 in the RUN status byte.
- Status consumer stalls (ack=0) across two pushes → second byte is reported with bit7=1; after it is consumed, the next byte has bit7=0.
- With MAC_LINK_WATCHDOG_EN and LINK_DOWN_CYCLES=5, drop link in RUN for 4 cycles then restore → no reset. Drop it for 5 cycles → pulse starts, status state=ASSERT.
- Assert reset during SETTLE → HELD next edge, RESET_N=0, status req=0; a HOLD (0x02) command in RUN → HELD, RESET_N=0 next edge.
